c1_bus_arbiter: RTL and testbench

- Arbiter and sequencer for the cache CPU-side (C1) bus, shared between two requesters (e.g. instruction and data ports).
- Each requester presents a whole transaction (command, split address, 32-bit write data) through a valid/ack handshake.
- The block wins arbitration, then drives the two-cycle C1 command/address phase and releases the bus.
- It waits for the cache's RESPONSE, captures read data (one or two words), and returns a one-cycle response pulse to the owning requester.

---
 rtl/c1_bus_arbiter_if.sv | 35 +++
 rtl/c1_bus_arbiter.sv | 156 +++++++++++++++
 tb/tb_c1_bus_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/c1_bus_arbiter_if.sv
// Requester handshake and C1 bus signals of the C1 bus arbiter.
// master = arbiter side, slave = requesters, cache and bus resolver.
interface c1_bus_arbiter_if #(
   parameter int ADDR_HI_W = 14,
   parameter int ADDR_LO_W = 4
);
   logic [1:0]             rq_valid;
   logic [5:0]             rq_cmd;
   logic [2*ADDR_HI_W-1:0] rq_addr_hi;
   logic [2*ADDR_LO_W-1:0] rq_addr_lo;
   logic [63:0]            rq_wdata;
   logic [1:0]             rq_ack;
   logic [1:0]             rsp_valid;
   logic [31:0]            rsp_rdata;
   logic                   rsp_err;
   logic [ADDR_HI_W-1:0]   c1_addr;
   logic [15:0]            c1_data_out;
   logic                   c1_data_oe;
   logic [15:0]            c1_data_in;
   logic [2:0]             c1_ctrl_out;
   logic                   c1_ctrl_oe;
   logic [2:0]             c1_ctrl_in;

   modport master (
      input  rq_valid, rq_cmd, rq_addr_hi, rq_addr_lo, rq_wdata, c1_data_in, c1_ctrl_in,
      output rq_ack, rsp_valid, rsp_rdata, rsp_err,
      output c1_addr, c1_data_out, c1_data_oe, c1_ctrl_out, c1_ctrl_oe
   );

   modport slave (
      output rq_valid, rq_cmd, rq_addr_hi, rq_addr_lo, rq_wdata, c1_data_in, c1_ctrl_in,
      input  rq_ack, rsp_valid, rsp_rdata, rsp_err,
      input  c1_addr, c1_data_out, c1_data_oe, c1_ctrl_out, c1_ctrl_oe
   );
endinterface

// File: rtl/c1_bus_arbiter.sv
// Round-robin arbiter/sequencer for the shared C1 bus; one transaction in flight at a time.
// Latency: cmd + addr2 cycles, then RESPONSE+1 (READ32 +2) to rsp_valid; requesters hold valid until rq_ack.
module c1_bus_arbiter #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int ADDR_HI_W      = 14,
   parameter int ADDR_LO_W      = 4
) (
   input logic              clk,
   input logic              reset,
   c1_bus_arbiter_if.master bus
);
   typedef enum logic [2:0] {IDLE, CMD, ADDR2, WAIT, RD2, RESP} state_t;

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] READ8    = 3'd1;
   localparam logic [2:0] READ16   = 3'd2;
   localparam logic [2:0] READ32   = 3'd3;
   localparam logic [2:0] WRITE8   = 3'd5;
   localparam logic [2:0] WRITE32  = 3'd7;
   localparam logic [2:0] RESPONSE = 3'd7;
   localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   state_t               state;
   logic                 last;
   logic                 gnt;
   logic [2:0]           cmd_q;
   logic [15:0]          whi_q;
   logic [ADDR_LO_W-1:0] alo_q;
   logic [CNT_W-1:0]     cnt;

   logic                 g_nxt;
   logic [1:0]           g_nxt_oh;
   logic [1:0]           gnt_oh;
   logic [2:0]           cmd_sel;
   logic [ADDR_HI_W-1:0] ahi_sel;
   logic [ADDR_LO_W-1:0] alo_sel;
   logic [31:0]          wdat_sel;

   // When both requesters are waiting, the one not served last wins.
   always_comb begin
      g_nxt = 1'b0;
      if (bus.rq_valid == 2'b11) begin
         g_nxt = ~last;
      end else if (bus.rq_valid[1]) begin
         g_nxt = 1'b1;
      end
   end

   assign g_nxt_oh = g_nxt ? 2'b10 : 2'b01;
   assign gnt_oh   = gnt ? 2'b10 : 2'b01;
   assign cmd_sel  = g_nxt ? bus.rq_cmd[5:3] : bus.rq_cmd[2:0];
   assign ahi_sel  = g_nxt ? bus.rq_addr_hi[2*ADDR_HI_W-1:ADDR_HI_W] : bus.rq_addr_hi[ADDR_HI_W-1:0];
   assign alo_sel  = g_nxt ? bus.rq_addr_lo[2*ADDR_LO_W-1:ADDR_LO_W] : bus.rq_addr_lo[ADDR_LO_W-1:0];
   assign wdat_sel = g_nxt ? bus.rq_wdata[63:32] : bus.rq_wdata[31:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         last            <= 1'b1;
         gnt             <= 1'b0;
         cmd_q           <= '0;
         whi_q           <= '0;
         alo_q           <= '0;
         cnt             <= '0;
         bus.rq_ack      <= '0;
         bus.rsp_valid   <= '0;
         bus.rsp_rdata   <= '0;
         bus.rsp_err     <= 1'b0;
         bus.c1_addr     <= '0;
         bus.c1_data_out <= '0;
         bus.c1_data_oe  <= 1'b0;
         bus.c1_ctrl_out <= OP_NOP;
         bus.c1_ctrl_oe  <= 1'b1;
      end else begin
         bus.rq_ack    <= '0;
         bus.rsp_valid <= '0;
         case (state)
            IDLE: begin
               if (|bus.rq_valid) begin
                  // Capture the whole request: fields may change once rq_ack is seen.
                  gnt           <= g_nxt;
                  last          <= g_nxt;
                  cmd_q         <= cmd_sel;
                  alo_q         <= alo_sel;
                  whi_q         <= wdat_sel[31:16];
                  bus.rq_ack    <= g_nxt_oh;
                  bus.rsp_rdata <= '0;
                  bus.rsp_err   <= 1'b0;
                  if (cmd_sel == OP_NOP) begin
                     bus.rsp_valid <= g_nxt_oh;
                     bus.rsp_err   <= 1'b1;
                     state         <= RESP;
                  end else begin
                     bus.c1_ctrl_out <= cmd_sel;
                     bus.c1_ctrl_oe  <= 1'b1;
                     bus.c1_addr     <= ahi_sel;
                     bus.c1_data_oe  <= (cmd_sel >= WRITE8);
                     bus.c1_data_out <= (cmd_sel == WRITE8) ? {8'h00, wdat_sel[7:0]} : wdat_sel[15:0];
                     state           <= CMD;
                  end
               end
            end
            CMD: begin
               bus.c1_addr <= ADDR_HI_W'(alo_q);
               if (cmd_q == WRITE32) begin
                  bus.c1_data_out <= whi_q;
               end
               state <= ADDR2;
            end
            ADDR2: begin
               bus.c1_ctrl_oe <= 1'b0;
               bus.c1_data_oe <= 1'b0;
               cnt            <= '0;
               state          <= WAIT;
            end
            WAIT: begin
               if (bus.c1_ctrl_in == RESPONSE) begin
                  case (cmd_q)
                     READ8:   bus.rsp_rdata <= {24'h0, bus.c1_data_in[7:0]};
                     READ16:  bus.rsp_rdata <= {16'h0, bus.c1_data_in};
                     READ32:  bus.rsp_rdata <= {16'h0, bus.c1_data_in};
                     default: bus.rsp_rdata <= '0;
                  endcase
                  if (cmd_q == READ32) begin
                     state <= RD2;
                  end else begin
                     bus.rsp_valid <= gnt_oh;
                     state         <= RESP;
                  end
               end else if (TIMEOUT_CYCLES != 0 && cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  bus.rsp_valid <= gnt_oh;
                  bus.rsp_err   <= 1'b1;
                  bus.rsp_rdata <= '0;
                  state         <= RESP;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RD2: begin
               bus.rsp_rdata[31:16] <= bus.c1_data_in;
               bus.rsp_valid        <= gnt_oh;
               state                <= RESP;
            end
            RESP: begin
               bus.c1_ctrl_out <= OP_NOP;
               bus.c1_ctrl_oe  <= 1'b1;
               bus.c1_data_oe  <= 1'b0;
               bus.c1_data_out <= '0;
               bus.c1_addr     <= '0;
               state           <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_c1_bus_arbiter.sv
// Bench for c1_bus_arbiter: directed cases plus random two-requester traffic
// checked against a transaction-level model (round-robin grant, bus phases, read assembly).
module tb_c1_bus_arbiter;
   localparam int TMO = 8;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_chk = 0;
   int   n_bad = 0;
   int   m_last;

   bit          p_vld [2];
   logic [2:0]  p_cmd [2];
   logic [13:0] p_hi  [2];
   logic [3:0]  p_lo  [2];
   logic [31:0] p_wd  [2];

   c1_bus_arbiter_if #(.ADDR_HI_W(14), .ADDR_LO_W(4)) bus ();

   c1_bus_arbiter #(.TIMEOUT_CYCLES(TMO), .ADDR_HI_W(14), .ADDR_LO_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [1:0] onehot(input int g);
      return (g != 0) ? 2'b10 : 2'b01;
   endfunction

   task automatic drive();
      bus.rq_valid   = {p_vld[1], p_vld[0]};
      bus.rq_cmd     = {p_cmd[1], p_cmd[0]};
      bus.rq_addr_hi = {p_hi[1], p_hi[0]};
      bus.rq_addr_lo = {p_lo[1], p_lo[0]};
      bus.rq_wdata   = {p_wd[1], p_wd[0]};
   endtask

   task automatic post(input int r, input logic [2:0] c, input logic [13:0] hi,
                       input logic [3:0] lo, input logic [31:0] wd);
      p_vld[r] = 1'b1;
      p_cmd[r] = c;
      p_hi[r]  = hi;
      p_lo[r]  = lo;
      p_wd[r]  = wd;
      drive();
   endtask

   // After the ack the requester scrambles its fields, so the DUT must have captured them.
   task automatic retire(input int r);
      p_vld[r] = 1'b0;
      p_cmd[r] = 3'($urandom);
      p_hi[r]  = 14'($urandom);
      p_lo[r]  = 4'($urandom);
      p_wd[r]  = $urandom;
      drive();
   endtask

   task automatic junk_cache();
      bus.c1_ctrl_in = 3'($urandom_range(0, 7));
      bus.c1_data_in = 16'($urandom);
   endtask

   task automatic check_reset_outs(input string tag);
      chk({tag, "_hs"}, {bus.rq_ack, bus.rsp_valid, bus.rsp_err}, 32'd0);
      chk({tag, "_rdata"}, bus.rsp_rdata, 32'd0);
      chk({tag, "_c1"}, {bus.c1_addr, bus.c1_data_out, bus.c1_data_oe}, 32'd0);
      chk({tag, "_ctrl"}, {bus.c1_ctrl_out, bus.c1_ctrl_oe}, 32'h1);
   endtask

   // Called in an IDLE cycle with at least one request pending; returns in the following IDLE cycle.
   // dly = WAIT cycle index carrying RESPONSE; dly >= TMO means the cache never answers.
   task automatic serve(input int dly, input logic [15:0] w0, input logic [15:0] w1);
      int          g;
      logic [2:0]  c;
      logic [13:0] hi;
      logic [3:0]  lo;
      logic [31:0] wd;
      logic [15:0] d1;
      logic [31:0] exp_rd;
      bit          responded;
      if (p_vld[0] && p_vld[1]) g = (m_last != 0) ? 0 : 1;
      else g = p_vld[1] ? 1 : 0;
      m_last = g;
      c  = p_cmd[g];
      hi = p_hi[g];
      lo = p_lo[g];
      wd = p_wd[g];
      d1 = (c == 3'd5) ? {8'h00, wd[7:0]} : wd[15:0];
      junk_cache();
      tick();
      chk("ack", bus.rq_ack, onehot(g));
      retire(g);
      if (c == 3'd0) begin
         chk("ill_rsp", bus.rsp_valid, onehot(g));
         chk("ill_err", bus.rsp_err, 32'd1);
         chk("ill_bus", {bus.c1_data_oe, bus.c1_ctrl_oe && (bus.c1_ctrl_out != 3'd0)}, 32'd0);
      end else begin
         chk("cmd_ctrl", {bus.c1_ctrl_oe, bus.c1_ctrl_out}, {1'b1, c});
         chk("cmd_addr", bus.c1_addr, hi);
         chk("cmd_doe", bus.c1_data_oe, c >= 3'd5);
         if (c >= 3'd5) chk("cmd_data", bus.c1_data_out, d1);
         junk_cache();
         tick();
         chk("a2_ack", bus.rq_ack, 32'd0);
         chk("a2_ctrl", {bus.c1_ctrl_oe, bus.c1_ctrl_out}, {1'b1, c});
         chk("a2_addr", bus.c1_addr, {10'h0, lo});
         if (c >= 3'd5) chk("a2_data", {bus.c1_data_oe, bus.c1_data_out}, {1'b1, (c == 3'd7) ? wd[31:16] : d1});
         junk_cache();
         tick();
         responded = 1'b0;
         for (int k = 0; k < TMO && !responded; k++) begin
            chk("wait_rel", {bus.c1_ctrl_oe, bus.c1_data_oe, bus.rsp_valid}, 32'd0);
            if (k == dly) begin
               bus.c1_ctrl_in = 3'd7;
               bus.c1_data_in = w0;
               responded = 1'b1;
            end else begin
               bus.c1_ctrl_in = 3'($urandom_range(0, 6));
               bus.c1_data_in = 16'($urandom);
            end
            tick();
         end
         if (responded && c == 3'd3) begin
            chk("rd2_rsp", bus.rsp_valid, 32'd0);
            bus.c1_ctrl_in = 3'($urandom_range(0, 7));
            bus.c1_data_in = w1;
            tick();
         end
         if (!responded) exp_rd = 32'd0;
         else if (c == 3'd1) exp_rd = {24'h0, w0[7:0]};
         else if (c == 3'd2) exp_rd = {16'h0, w0};
         else exp_rd = {w1, w0};
         chk("rsp_vld", bus.rsp_valid, onehot(g));
         chk("rsp_err", bus.rsp_err, {31'h0, !responded});
         if (!responded || c <= 3'd3) chk("rsp_rdata", bus.rsp_rdata, exp_rd);
         chk("rsp_bus", {bus.c1_ctrl_oe, bus.c1_data_oe}, 32'd0);
      end
      junk_cache();
      tick();
      chk("idle", {bus.rsp_valid, bus.rq_ack, bus.c1_ctrl_oe, bus.c1_ctrl_out, bus.c1_data_oe}, 32'b00_00_1_000_0);
   endtask

   initial begin
      m_last = 1;
      for (int r = 0; r < 2; r++) begin
         p_vld[r] = 1'b0;
         p_cmd[r] = '0;
         p_hi[r]  = '0;
         p_lo[r]  = '0;
         p_wd[r]  = '0;
      end
      drive();
      bus.c1_ctrl_in = '0;
      bus.c1_data_in = '0;
      tick();
      tick();
      check_reset_outs("rst");

      // Both requesters valid out of reset: grants alternate 0,1,0,1.
      post(0, 3'd2, 14'h0123, 4'h2, 32'h0);
      post(1, 3'd1, 14'h0456, 4'h3, 32'h0);
      tick();
      reset = 1'b0;
      serve(1, 16'h1111, 16'h0);
      post(0, 3'd3, 14'h0789, 4'h8, 32'h0);
      serve(2, 16'h2468, 16'h1357);
      post(1, 3'd4, 14'h0abc, 4'h0, 32'h0);
      serve(0, 16'h5555, 16'h0);
      serve(5, 16'h0f0f, 16'h0);

      post(0, 3'd5, 14'h0, 4'h0, 32'h0000aa11);
      serve(3, 16'h0, 16'h0);
      post(0, 3'd7, 14'h0, 4'h0, 32'h44443333);
      serve(2, 16'h0, 16'h0);
      post(0, 3'd3, 14'h0, 4'h0, 32'h0);
      serve(1, 16'h3333, 16'h4444);
      post(0, 3'd1, 14'h0, 4'h6, 32'h0);
      serve(0, 16'hbe55, 16'h0);
      post(0, 3'd2, 14'h0, 4'h4, 32'h0);
      serve(4, 16'h2222, 16'h0);
      post(0, 3'd2, 14'h3fff, 4'hf, 32'h0);
      serve(99, 16'hdead, 16'h0);
      post(1, 3'd0, 14'h1234, 4'h5, 32'hffffffff);
      serve(0, 16'h0, 16'h0);
      post(0, 3'd6, 14'h2aaa, 4'h9, 32'h12345678);
      serve(TMO - 1, 16'h0, 16'h0);

      // Reset in the middle of WAIT: outputs drop asynchronously, no response, pointer restarts.
      post(0, 3'd2, 14'h0155, 4'h1, 32'h0);
      tick();
      chk("mw_ack", bus.rq_ack, 32'h1);
      retire(0);
      bus.c1_ctrl_in = 3'd0;
      tick();
      tick();
      tick();
      tick();
      #2 reset = 1'b1;
      #1 check_reset_outs("async");
      post(0, 3'd1, 14'h0011, 4'h2, 32'h0);
      post(1, 3'd1, 14'h0022, 4'h3, 32'h0);
      m_last = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_norsp", bus.rsp_valid, 32'd0);
      end
      reset = 1'b0;
      serve(2, 16'h00c3, 16'h0);
      serve(2, 16'h003c, 16'h0);

      for (int it = 0; it < 150; it++) begin
         for (int r = 0; r < 2; r++) begin
            if (!p_vld[r] && $urandom_range(0, 2) != 0)
               post(r, ($urandom_range(0, 9) == 0) ? 3'd0 : 3'($urandom_range(1, 7)),
                    14'($urandom), 4'($urandom), $urandom);
         end
         if (!p_vld[0] && !p_vld[1])
            post(int'($urandom_range(0, 1)), 3'($urandom_range(1, 7)), 14'($urandom), 4'($urandom), $urandom);
         serve(int'($urandom_range(0, 10)), 16'($urandom), 16'($urandom));
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
